// File: rtl/serializer_link_sequencer.sv
// Purpose: brings up and supervises the TMDS serializer (lock qualify, reset hold, CTL0 training, live video).
// Latency: outputs registered from next state; video passes tmds_video -> tmds_internal in 1 cycle while in RUN.
// Backpressure: none; the serializer consumes one word per channel every pixel clock.
module serializer_link_sequencer #(
   parameter int NUM_CHANNELS      = 3,
   parameter int LOCK_FILTER       = 8,
   parameter int RESET_HOLD_CYCLES = 16,
   parameter int TRAIN_CYCLES      = 1024
) (
   input  logic                         clk_pixel,
   input  logic                         reset,
   input  logic                         pll_locked,
   input  logic                         enable,
   input  logic                         retrain,
   input  logic [NUM_CHANNELS-1:0][9:0] tmds_video,
   output logic [NUM_CHANNELS-1:0][9:0] tmds_internal,
   output logic                         serializer_reset,
   output logic                         link_up,
   output logic [1:0]                   link_state
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_HOLD  = 2'd1,
      ST_TRAIN = 2'd2,
      ST_RUN   = 2'd3
   } state_t;

   localparam int LW        = $clog2(LOCK_FILTER + 1);
   localparam int PHASE_MAX = (RESET_HOLD_CYCLES > TRAIN_CYCLES) ? RESET_HOLD_CYCLES : TRAIN_CYCLES;
   localparam int PW        = $clog2(PHASE_MAX + 1);

   localparam logic [LW-1:0] LOCK_MAX   = LW'(LOCK_FILTER);
   localparam logic [PW-1:0] HOLD_LAST  = PW'(RESET_HOLD_CYCLES - 1);
   localparam logic [PW-1:0] TRAIN_LAST = PW'(TRAIN_CYCLES - 1);
   localparam logic [9:0]    CTL0       = 10'b1101010100;

   logic                         lock_meta;
   logic                         locked_sync;
   logic [LW-1:0]                lock_cnt;
   logic                         lock_ok;
   state_t                       state, state_nxt;
   logic [PW-1:0]                phase_cnt, phase_nxt;
   logic [NUM_CHANNELS-1:0][9:0] tmds_nxt;
   logic                         ser_rst_nxt;
   logic                         link_up_nxt;

   // Two-flop synchronizer for the PLL lock, the only asynchronous input.
   always_ff @(posedge clk_pixel) begin
      if (reset) begin
         lock_meta   <= 1'b0;
         locked_sync <= 1'b0;
      end else begin
         lock_meta   <= pll_locked;
         locked_sync <= lock_meta;
      end
   end

   // Lock filter: count consecutive synchronized lock cycles, saturating; any drop restarts it.
   always_ff @(posedge clk_pixel) begin
      if (reset || !locked_sync) begin
         lock_cnt <= '0;
      end else if (lock_cnt != LOCK_MAX) begin
         lock_cnt <= lock_cnt + LW'(1);
      end
   end

   assign lock_ok = (lock_cnt == LOCK_MAX);

   // Next state, phase counter and next output values; overrides applied lowest priority first.
   always_comb begin
      state_nxt   = state;
      phase_nxt   = phase_cnt;
      tmds_nxt    = '0;
      ser_rst_nxt = 1'b1;
      link_up_nxt = 1'b0;

      case (state)
         ST_IDLE: begin
            if (lock_ok && enable) begin
               state_nxt = ST_HOLD;
               phase_nxt = '0;
            end
         end
         ST_HOLD: begin
            if (phase_cnt == HOLD_LAST) begin
               state_nxt = ST_TRAIN;
               phase_nxt = '0;
            end else begin
               phase_nxt = phase_cnt + PW'(1);
            end
         end
         ST_TRAIN: begin
            if (phase_cnt == TRAIN_LAST) begin
               state_nxt = ST_RUN;
               phase_nxt = '0;
            end else begin
               phase_nxt = phase_cnt + PW'(1);
            end
         end
         ST_RUN: begin
            state_nxt = ST_RUN;
         end
         default: begin
            state_nxt = ST_IDLE;
            phase_nxt = '0;
         end
      endcase

      // A retrain re-enters HOLD from any active state with a fresh count.
      if (retrain && (state != ST_IDLE)) begin
         state_nxt = ST_HOLD;
         phase_nxt = '0;
      end

      // Losing lock or enable always wins over retrain.
      if (!locked_sync || !enable) begin
         state_nxt = ST_IDLE;
         phase_nxt = '0;
      end

      case (state_nxt)
         ST_TRAIN: begin
            ser_rst_nxt = 1'b0;
            tmds_nxt    = {NUM_CHANNELS{CTL0}};
         end
         ST_RUN: begin
            ser_rst_nxt = 1'b0;
            tmds_nxt    = tmds_video;
            link_up_nxt = 1'b1;
         end
         default: begin
            ser_rst_nxt = 1'b1;
            tmds_nxt    = '0;
         end
      endcase
   end

   // State, phase counter and registered outputs all update on the same edge.
   always_ff @(posedge clk_pixel) begin
      if (reset) begin
         state            <= ST_IDLE;
         phase_cnt        <= '0;
         tmds_internal    <= '0;
         serializer_reset <= 1'b1;
         link_up          <= 1'b0;
      end else begin
         state            <= state_nxt;
         phase_cnt        <= phase_nxt;
         tmds_internal    <= tmds_nxt;
         serializer_reset <= ser_rst_nxt;
         link_up          <= link_up_nxt;
      end
   end

   assign link_state = state;

endmodule

// File: tb/tb_serializer_link_sequencer.sv
// Bench for serializer_link_sequencer: scripted bring-up/lock/retrain/reset scenarios plus random traffic.
// Every edge is compared against a cycle-count reference model of the link rules.
// Inputs change 1 time unit after the rising edge; outputs are sampled there too.
module tb_serializer_link_sequencer;

   localparam int NCH = 3;
   localparam int LF  = 4;
   localparam int RHC = 8;
   localparam int TC  = 32;
   localparam logic [9:0] CTL0 = 10'b1101010100;

   logic                clk_pixel = 1'b0;
   logic                reset = 1'b1;
   logic                pll_locked = 1'b0;
   logic                enable = 1'b0;
   logic                retrain = 1'b0;
   logic [NCH-1:0][9:0] tmds_video = '0;
   logic [NCH-1:0][9:0] tmds_internal;
   logic                serializer_reset;
   logic                link_up;
   logic [1:0]          link_state;

   int checks = 0;
   int errors = 0;

   // reference model state
   logic        m_s0, m_s1;
   int          m_run;
   int          m_st;
   int          m_age;
   logic [29:0] m_tmds;

   serializer_link_sequencer #(
      .NUM_CHANNELS(NCH), .LOCK_FILTER(LF), .RESET_HOLD_CYCLES(RHC), .TRAIN_CYCLES(TC)
   ) dut (
      .clk_pixel(clk_pixel), .reset(reset), .pll_locked(pll_locked), .enable(enable),
      .retrain(retrain), .tmds_video(tmds_video), .tmds_internal(tmds_internal),
      .serializer_reset(serializer_reset), .link_up(link_up), .link_state(link_state)
   );

   always #5 clk_pixel = ~clk_pixel;

   initial begin
      #2000000;
      $display("FAIL timeout checks=%0d errors=%0d", checks, errors);
      $fatal(1, "timeout");
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   // Model of one rising edge, using the inputs as they stood at that edge.
   task automatic model_edge();
      logic ls;
      logic ok;
      if (reset) begin
         m_s0 = 0; m_s1 = 0; m_run = 0; m_st = 0; m_age = 0; m_tmds = '0;
      end else begin
         ls = m_s1;
         ok = (m_run == LF);
         m_s1 = m_s0;
         m_s0 = pll_locked;
         if (!ls) m_run = 0;
         else if (m_run < LF) m_run = m_run + 1;
         if (!ls || !enable) begin
            m_st = 0; m_age = 0;
         end else if (retrain && m_st != 0) begin
            m_st = 1; m_age = 0;
         end else if (m_st == 0) begin
            if (ok) begin m_st = 1; m_age = 0; end
         end else if (m_st == 1) begin
            m_age = m_age + 1;
            if (m_age == RHC) begin m_st = 2; m_age = 0; end
         end else if (m_st == 2) begin
            m_age = m_age + 1;
            if (m_age == TC) begin m_st = 3; m_age = 0; end
         end
         if (m_st == 3)      m_tmds = tmds_video;
         else if (m_st == 2) m_tmds = {3{CTL0}};
         else                m_tmds = '0;
      end
   endtask

   task automatic tick();
      @(posedge clk_pixel);
      model_edge();
      #1;
      chk("m_state", {30'd0, link_state}, m_st);
      chk("m_ser_reset", {31'd0, serializer_reset}, (m_st < 2) ? 1 : 0);
      chk("m_link_up", {31'd0, link_up}, (m_st == 3) ? 1 : 0);
      chk("m_tmds", {2'd0, tmds_internal}, {2'd0, m_tmds});
   endtask

   task automatic ticks(input int n);
      for (int k = 0; k < n; k++) tick();
   endtask

   task automatic check_reset_values(input string tag);
      chk({tag, "_state"}, {30'd0, link_state}, 0);
      chk({tag, "_ser_reset"}, {31'd0, serializer_reset}, 1);
      chk({tag, "_link_up"}, {31'd0, link_up}, 0);
      chk({tag, "_tmds"}, {2'd0, tmds_internal}, 0);
   endtask

   // Bring-up from lock release: HOLD at edge 3+LF, TRAIN at +RHC, RUN at +TC.
   task automatic bringup(input string tag);
      for (int e = 1; e <= 3 + LF + RHC + TC; e++) begin
         tick();
         if (e == 2 + LF)           chk({tag, "_pre_hold"}, {30'd0, link_state}, 0);
         if (e == 3 + LF)           chk({tag, "_hold"}, {30'd0, link_state}, 1);
         if (e == 2 + LF + RHC)     chk({tag, "_sres_hi"}, {31'd0, serializer_reset}, 1);
         if (e == 3 + LF + RHC) begin
            chk({tag, "_sres_lo"}, {31'd0, serializer_reset}, 0);
            chk({tag, "_ctl0"}, {2'd0, tmds_internal}, {2'd0, CTL0, CTL0, CTL0});
         end
         if (e == 2 + LF + RHC + TC) chk({tag, "_lup_lo"}, {31'd0, link_up}, 0);
         if (e == 3 + LF + RHC + TC) chk({tag, "_lup_hi"}, {31'd0, link_up}, 1);
      end
   endtask

   initial begin
      logic [9:0] v0, v1, v2;

      // reset state
      tick();
      check_reset_values("rst");
      tick();

      // bring-up
      reset = 0; pll_locked = 1; enable = 1;
      bringup("bu");

      // video pass-through
      v0 = 10'h2AA; v1 = 10'h155; v2 = 10'h3FF;
      for (int c = 0; c < 12; c++) begin
         tmds_video = {v2, v1, v0};
         tick();
         chk("vid", {2'd0, tmds_internal}, {2'd0, v2, v1, v0});
         v0 = v0 + 10'd1; v1 = v1 + 10'd1; v2 = v2 + 10'd1;
      end

      // one-cycle lock loss in RUN
      pll_locked = 0;
      for (int j = 1; j <= 8; j++) begin
         tick();
         if (j == 1) pll_locked = 1;
         if (j == 2) chk("loss_still_run", {30'd0, link_state}, 3);
         if (j == 3) check_reset_values("loss");
         if (j == 7) chk("loss_pre_hold", {30'd0, link_state}, 0);
         if (j == 8) chk("loss_hold", {30'd0, link_state}, 1);
      end
      ticks(RHC + TC);
      chk("loss_rerun", {31'd0, link_up}, 1);

      // lock chatter never qualifies
      reset = 1; pll_locked = 0;
      tick();
      reset = 0;
      for (int c = 0; c < 100; c++) begin
         pll_locked = ((c / 3) % 2) != 0;
         tick();
         chk("chatter_state", {30'd0, link_state}, 0);
         chk("chatter_sres", {31'd0, serializer_reset}, 1);
      end

      // back to RUN, then retrain in RUN
      pll_locked = 1;
      ticks(3 + LF + RHC + TC);
      chk("pre_retrain_run", {30'd0, link_state}, 3);
      retrain = 1;
      tick();
      retrain = 0;
      chk("retrain_hold", {30'd0, link_state}, 1);
      for (int j = 1; j <= RHC + TC; j++) begin
         tick();
         if (j == RHC - 1)    chk("rt_hold_end", {30'd0, link_state}, 1);
         if (j == RHC)        chk("rt_train", {30'd0, link_state}, 2);
         if (j == RHC + TC - 1) chk("rt_train_end", {30'd0, link_state}, 2);
         if (j == RHC + TC)   chk("rt_run", {30'd0, link_state}, 3);
      end

      // retrain in mid-TRAIN restarts HOLD from zero
      retrain = 1;
      tick();
      retrain = 0;
      ticks(RHC + 15);
      chk("mid_train", {30'd0, link_state}, 2);
      retrain = 1;
      tick();
      retrain = 0;
      chk("mt_hold", {30'd0, link_state}, 1);
      for (int j = 1; j <= RHC; j++) begin
         tick();
         if (j == RHC - 1) chk("mt_hold_end", {30'd0, link_state}, 1);
         if (j == RHC)     chk("mt_train", {30'd0, link_state}, 2);
      end

      // retrain with enable low: IDLE wins
      retrain = 1; enable = 0;
      tick();
      chk("rt_vs_disable", {30'd0, link_state}, 0);
      retrain = 0; enable = 1;

      // reset mid-TRAIN
      ticks(1 + RHC + 3);
      chk("pre_rst_train", {30'd0, link_state}, 2);
      reset = 1;
      tick();
      check_reset_values("mid_rst");
      reset = 0;
      bringup("rebu");

      // randomized traffic
      for (int c = 0; c < 3000; c++) begin
         pll_locked = ($urandom_range(0, 149) != 0);
         enable     = ($urandom_range(0, 249) != 0);
         retrain    = ($urandom_range(0, 99) == 0);
         reset      = ($urandom_range(0, 799) == 0);
         tmds_video = {10'($urandom), 10'($urandom), 10'($urandom)};
         tick();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
